// File: rtl/halloween_pkg.sv
// Shared opcode map, output encodings and FSM state type for the Halloween
// show sequencer.
package halloween_pkg;

   localparam logic [3:0] OP_ON     = 4'b0000;
   localparam logic [3:0] OP_RESET  = 4'b0001;
   localparam logic [3:0] OP_GREEN  = 4'b0100;
   localparam logic [3:0] OP_PURPLE = 4'b0101;
   localparam logic [3:0] OP_ORANGE = 4'b0110;
   localparam logic [3:0] OP_SCREAM = 4'b1000;
   localparam logic [3:0] OP_CACKLE = 4'b1001;
   localparam logic [3:0] OP_BOO    = 4'b1010;
   localparam logic [3:0] OP_WAVE   = 4'b1100;
   localparam logic [3:0] OP_JAW    = 4'b1101;
   localparam logic [3:0] OP_FOG    = 4'b1110;

   localparam logic [1:0] COL_GREEN  = 2'b00;
   localparam logic [1:0] COL_PURPLE = 2'b01;
   localparam logic [1:0] COL_ORANGE = 2'b10;

   localparam logic [1:0] SND_SCREAM = 2'b00;
   localparam logic [1:0] SND_CACKLE = 2'b01;
   localparam logic [1:0] SND_BOO    = 2'b10;

   localparam logic [2:0] EFF_NONE = 3'b000;
   localparam logic [2:0] EFF_WAVE = 3'b001;
   localparam logic [2:0] EFF_JAW  = 3'b010;
   localparam logic [2:0] EFF_FOG  = 3'b100;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         OP_ON, OP_RESET,
         OP_GREEN, OP_PURPLE, OP_ORANGE,
         OP_SCREAM, OP_CACKLE, OP_BOO,
         OP_WAVE, OP_JAW, OP_FOG: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/halloween_op_decode.sv
// Combinational opcode decoder: splits one slot opcode into colour, sound,
// effect, reset and illegal indications.
module halloween_op_decode
   import halloween_pkg::*;
(
   input  logic [3:0] op,
   output logic       color_we,
   output logic [1:0] color,
   output logic       sound_v,
   output logic [1:0] sound_id,
   output logic [2:0] effect,
   output logic       is_reset,
   output logic       illegal
);

   always_comb begin
      color_we = 1'b0;
      color    = COL_GREEN;
      sound_v  = 1'b0;
      sound_id = SND_SCREAM;
      effect   = EFF_NONE;
      is_reset = 1'b0;
      illegal  = !is_legal(op);
      case (op)
         OP_RESET:  is_reset = 1'b1;
         OP_GREEN:  begin color_we = 1'b1; color = COL_GREEN;  end
         OP_PURPLE: begin color_we = 1'b1; color = COL_PURPLE; end
         OP_ORANGE: begin color_we = 1'b1; color = COL_ORANGE; end
         OP_SCREAM: begin sound_v = 1'b1; sound_id = SND_SCREAM; end
         OP_CACKLE: begin sound_v = 1'b1; sound_id = SND_CACKLE; end
         OP_BOO:    begin sound_v = 1'b1; sound_id = SND_BOO;    end
         OP_WAVE:   effect = EFF_WAVE;
         OP_JAW:    effect = EFF_JAW;
         OP_FOG:    effect = EFF_FOG;
         default:   ;
      endcase
   end

endmodule

// File: rtl/halloween_sequencer.sv
// Slot sequencer: walks NUM_SLOTS opcode slots with a programmable dwell and
// drives registered lamp, speaker and actuator outputs.
module halloween_sequencer
   import halloween_pkg::*;
#(
   parameter  int NUM_SLOTS = 4,
   parameter  int DWELL_W   = 8,
   localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [4*NUM_SLOTS-1:0] prog,
   input  logic [DWELL_W-1:0]     dwell,
   output logic                   running,
   output logic [IDX_W-1:0]       step_idx,
   output logic [3:0]             opcode,
   output logic [1:0]             color,
   output logic                   color_valid,
   output logic                   sound_pulse,
   output logic [1:0]             sound_id,
   output logic [2:0]             effect,
   output logic                   err
);

   state_t                 state;
   logic [4*NUM_SLOTS-1:0] snapshot;
   logic [DWELL_W-1:0]     dwell_cnt;
   logic                   reset_step;

   logic                   wrap;
   logic                   enter_step;
   logic                   do_reset;
   logic [IDX_W-1:0]       next_idx;
   logic [3:0]             next_op;

   logic                   dec_color_we;
   logic [1:0]             dec_color;
   logic                   dec_sound_v;
   logic [1:0]             dec_sound_id;
   logic [2:0]             dec_effect;
   logic                   dec_is_reset;
   logic                   dec_illegal;

   assign wrap       = (step_idx == IDX_W'(NUM_SLOTS - 1));
   assign enter_step = (state == IDLE) || (dwell_cnt == '0);

   // Slot 0 on start and wrap comes straight from prog because the snapshot
   // is reloaded on that same edge; after a RESET step it was already reloaded.
   always_comb begin
      next_idx = '0;
      next_op  = prog[3:0];
      if (state == RUN && !reset_step && !wrap) begin
         next_idx = step_idx + IDX_W'(1);
         next_op  = '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (IDX_W'(i) == next_idx) next_op = snapshot[4*i +: 4];
         end
      end else if (state == RUN && reset_step) begin
         next_op = snapshot[3:0];
      end
   end

   halloween_op_decode u_dec (
      .op       (next_op),
      .color_we (dec_color_we),
      .color    (dec_color),
      .sound_v  (dec_sound_v),
      .sound_id (dec_sound_id),
      .effect   (dec_effect),
      .is_reset (dec_is_reset),
      .illegal  (dec_illegal)
   );

   // A RESET in slot 0 would jump straight back to itself, so it runs as ON.
   assign do_reset = dec_is_reset && (next_idx != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         snapshot    <= '0;
         dwell_cnt   <= '0;
         reset_step  <= 1'b0;
         running     <= 1'b0;
         step_idx    <= '0;
         opcode      <= '0;
         color       <= '0;
         color_valid <= 1'b0;
         sound_pulse <= 1'b0;
         sound_id    <= '0;
         effect      <= '0;
         err         <= 1'b0;
      end else if (!enable) begin
         state       <= IDLE;
         dwell_cnt   <= '0;
         reset_step  <= 1'b0;
         running     <= 1'b0;
         step_idx    <= '0;
         sound_pulse <= 1'b0;
         effect      <= '0;
      end else if (enter_step) begin
         state       <= RUN;
         running     <= 1'b1;
         step_idx    <= next_idx;
         opcode      <= next_op;
         sound_pulse <= dec_sound_v;
         effect      <= dec_effect;
         reset_step  <= do_reset;
         dwell_cnt   <= do_reset ? '0 : dwell;
         if (dec_color_we) begin
            color       <= dec_color;
            color_valid <= 1'b1;
         end
         if (dec_sound_v) sound_id <= dec_sound_id;
         if (dec_illegal) err <= 1'b1;
         if (do_reset) begin
            color       <= COL_GREEN;
            color_valid <= 1'b0;
            snapshot    <= prog;
         end else if (next_idx == '0 && !reset_step) begin
            snapshot <= prog;
         end
      end else begin
         dwell_cnt   <= dwell_cnt - DWELL_W'(1);
         sound_pulse <= 1'b0;
      end
   end

endmodule

// File: tb/tb_halloween_sequencer.sv
// Scoreboard bench: a behavioural model predicts every cycle for a 4-slot and
// a 3-slot sequencer; predictions are queued before each edge and checked after.
module tb_halloween_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en4, en3;
   logic [15:0] prog4;
   logic [11:0] prog3;
   logic [7:0]  dwell4, dwell3;

   logic       run4, cv4, sp4, err4, run3, cv3, sp3, err3;
   logic [1:0] idx4, col4, sid4, idx3, col3, sid3;
   logic [3:0] op4, op3;
   logic [2:0] eff4, eff3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   halloween_sequencer #(.NUM_SLOTS(4), .DWELL_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(en4), .prog(prog4), .dwell(dwell4),
      .running(run4), .step_idx(idx4), .opcode(op4), .color(col4),
      .color_valid(cv4), .sound_pulse(sp4), .sound_id(sid4), .effect(eff4),
      .err(err4));

   halloween_sequencer #(.NUM_SLOTS(3), .DWELL_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .enable(en3), .prog(prog3), .dwell(dwell3),
      .running(run3), .step_idx(idx3), .opcode(op3), .color(col3),
      .color_valid(cv3), .sound_pulse(sp3), .sound_id(sid3), .effect(eff3),
      .err(err3));

   typedef struct {
      logic        run;
      int          idx;
      logic [7:0]  cnt;
      logic [15:0] snap;
      logic        rstep;
      logic [3:0]  op;
      logic [1:0]  col;
      logic        cv;
      logic        sp;
      logic [1:0]  sid;
      logic [2:0]  eff;
      logic        err;
   } mst_t;

   mst_t m4, m3;
   mst_t q4[$];
   mst_t q3[$];
   int   max_idx3 = 0;
   logic b2b_seen3 = 1'b0;
   logic prev_sp3 = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference behaviour for one clock edge with rst_n high.
   function automatic mst_t mnext(mst_t s, int n, logic en, logic [15:0] p, logic [7:0] d);
      mst_t r;
      int ni;
      logic [3:0] op;
      r = s;
      r.sp = 1'b0;
      if (!en) begin
         r.run = 0; r.eff = 0; r.idx = 0; r.cnt = 0; r.rstep = 0;
         return r;
      end
      if (s.run && s.cnt != 0) begin
         r.cnt = s.cnt - 8'd1;
         return r;
      end
      if (!s.run || (!s.rstep && s.idx == n - 1)) begin
         ni = 0;
         r.snap = p;
      end else if (s.rstep) ni = 0;
      else ni = s.idx + 1;
      op = r.snap[4*ni +: 4];
      r.run = 1; r.idx = ni; r.op = op; r.cnt = d; r.eff = 0; r.rstep = 0;
      case (op)
         4'h4, 4'h5, 4'h6:    begin r.col = 2'(op - 4'h4); r.cv = 1; end
         4'h8, 4'h9, 4'hA:    begin r.sp = 1; r.sid = 2'(op - 4'h8); end
         4'hC, 4'hD, 4'hE:    r.eff = 3'(1 << (op - 4'hC));
         4'h1: if (ni != 0) begin
            r.col = 0; r.cv = 0; r.cnt = 0; r.rstep = 1; r.snap = p;
         end
         4'h0: ;
         default: r.err = 1;
      endcase
      return r;
   endfunction

   task automatic cmp(input string who, input mst_t e, input logic run, input logic [1:0] idx,
                      input logic [3:0] op, input logic [1:0] col, input logic cv, input logic sp,
                      input logic [1:0] sid, input logic [2:0] eff, input logic er);
      check({who, " running"}, run, e.run);
      check({who, " step_idx"}, idx, e.idx);
      check({who, " opcode"}, op, e.op);
      check({who, " color"}, col, e.col);
      check({who, " color_valid"}, cv, e.cv);
      check({who, " sound_pulse"}, sp, e.sp);
      check({who, " sound_id"}, sid, e.sid);
      check({who, " effect"}, eff, e.eff);
      check({who, " err"}, er, e.err);
   endtask

   task automatic tick();
      mst_t e4, e3;
      if (!rst_n) begin
         e4 = '{default: 0};
         e3 = '{default: 0};
      end else begin
         e4 = mnext(m4, 4, en4, prog4, dwell4);
         e3 = mnext(m3, 3, en3, {4'h0, prog3}, dwell3);
      end
      q4.push_back(e4);
      q3.push_back(e3);
      m4 = e4;
      m3 = e3;
      @(posedge clk);
      #1;
      cmp("d4", q4.pop_front(), run4, idx4, op4, col4, cv4, sp4, sid4, eff4, err4);
      cmp("d3", q3.pop_front(), run3, idx3, op3, col3, cv3, sp3, sid3, eff3, err3);
      if (int'(idx3) > max_idx3) max_idx3 = int'(idx3);
      if (prev_sp3 && sp3) b2b_seen3 = 1'b1;
      prev_sp3 = sp3;
   endtask

   initial begin
      int pulses;
      int n;
      logic [3:0] seen2, seen3;
      rst_n = 0; en4 = 0; en3 = 0; prog4 = '0; prog3 = '0; dwell4 = '0; dwell3 = '0;
      m4 = '{default: 0};
      m3 = '{default: 0};
      tick();
      tick();
      check("reset d4 outputs", {run4, idx4, op4, col4, cv4, sp4, sid4, eff4, err4}, 0);
      rst_n = 1;

      // Basic sequence on the 4-slot unit, 3-slot unit runs dwell=0 alongside.
      prog4 = 16'h6EA4; dwell4 = 8'd2; en4 = 1;
      prog3 = 12'hC98;  dwell3 = 8'd0; en3 = 1;
      tick();
      check("basic first op", op4, 4'h4);
      check("basic first cv", cv4, 1);
      check("basic first color", col4, 2'b00);
      pulses = int'(sp4);
      for (int i = 2; i <= 12; i++) begin
         tick();
         pulses += int'(sp4);
         if (i == 4) check("basic boo id", sid4, 2'b10);
         if (i == 8) check("basic fog", eff4, 3'b100);
         if (i == 11) check("basic orange", col4, 2'b10);
      end
      check("basic pulse count", pulses, 1);
      tick();
      check("basic wrap idx", idx4, 0);
      check("basic wrap op", op4, 4'h4);

      // Mid-run program change takes effect only at slot-0 re-entry.
      n = 0;
      while (idx4 != 2'd1 && n < 10) begin tick(); n++; end
      check("wait slot1 timeout", idx4, 1);
      prog4 = 16'h5C98;
      seen2 = '0; seen3 = '0;
      n = 0;
      do begin
         tick(); n++;
         if (idx4 == 2'd2) seen2 = op4;
         if (idx4 == 2'd3) seen3 = op4;
      end while (idx4 != 2'd0 && n < 20);
      check("wait wrap timeout", idx4, 0);
      check("old slot2 op", seen2, 4'hE);
      check("old slot3 op", seen3, 4'h6);
      check("new slot0 op", op4, 4'h8);
      check("new slot0 pulse", sp4, 1);

      // Enable drop on a step-boundary edge.
      tick();
      tick();
      en4 = 0;
      tick();
      check("drop running", run4, 0);
      check("drop effect", eff4, 0);
      check("drop idx", idx4, 0);
      check("drop color held", col4, 2'b10);
      check("drop cv held", cv4, 1);

      // RESET opcode in slot 3.
      prog4 = 16'h1A54; dwell4 = 8'd3; en4 = 1;
      n = 0;
      do begin tick(); n++; end while (op4 != 4'h1 && n < 30);
      check("reset op seen", op4, 4'h1);
      check("reset step idx", idx4, 3);
      check("reset cv cleared", cv4, 0);
      tick();
      check("after reset idx", idx4, 0);
      check("after reset op", op4, 4'h4);
      check("after reset cv", cv4, 1);

      // Illegal opcodes in slots 1 and 2.
      en4 = 0;
      tick();
      prog4 = 16'h0734; dwell4 = 8'd1; en4 = 1;
      tick();
      check("illegal pre err", err4, 0);
      tick();
      tick();
      check("illegal err set", err4, 1);
      check("illegal idx", idx4, 1);
      tick();
      check("illegal dwell held", idx4, 1);
      check("illegal color unchanged", col4, 2'b00);
      en4 = 0;
      tick();
      check("err survives disable", err4, 1);
      en4 = 1;
      tick();
      check("err survives restart", err4, 1);
      tick();

      // Asynchronous reset mid-dwell, between clock edges.
      #3;
      rst_n = 0;
      #1;
      check("async rst d4", {run4, idx4, op4, col4, cv4, sp4, sid4, eff4, err4}, 0);
      check("async rst d3", {run3, idx3, op3, col3, cv3, sp3, sid3, eff3, err3}, 0);
      m4 = '{default: 0};
      m3 = '{default: 0};
      tick();
      rst_n = 1;
      for (int i = 0; i < 6; i++) tick();

      check("d3 idx below 3", (max_idx3 < 3), 1);
      check("d3 back-to-back pulses", b2b_seen3, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
